// File: rtl/pipe_in_fifo.sv
// Host-to-endpoint pipe FIFO with first-word-fall-through output, block throttle and sticky overflow.
// Optional dropped-write counter on ep_dropcount is enabled by defining PIPE_IN_FIFO_DROP_COUNT_EN.
module pipe_in_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter logic [7:0]  EP_ADDR    = 8'h80
) (
    input  logic                         ti_clk,
    input  logic                         ti_reset,
    input  logic [7:0]                   ti_addr,
    input  logic                         ti_write,
    input  logic [DATA_WIDTH-1:0]        ti_datain,
    output logic                         ti_ready,
    output logic                         ep_blockready,
    output logic                         ep_valid,
    input  logic                         ep_ready,
    output logic [DATA_WIDTH-1:0]        ep_dataout,
    output logic [$clog2(DEPTH+1)-1:0]   ep_count,
    output logic                         ep_overflow,
    input  logic                         ep_overflow_clr
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0]                  ep_dropcount
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BLOCK_C = CW'(BLOCK_SIZE);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  primed_r;
    logic                  overflow_r;

    logic                  addr_hit_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [CW-1:0]         free_s;

    // Handshake decode and status flags, all derived from the count register.
    always_comb begin
        addr_hit_s    = 1'b0;
        full_s        = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        drop_s        = 1'b0;
        free_s        = {CW{1'b0}};
        ep_valid      = 1'b0;
        ti_ready      = 1'b0;
        ep_blockready = 1'b0;
        if (ti_addr == EP_ADDR) begin
            addr_hit_s = 1'b1;
        end else begin
            addr_hit_s = 1'b0;
        end
        full_s        = (count_r == DEPTH_C);
        ep_valid      = (count_r != {CW{1'b0}});
        pop_s         = ep_valid && ep_ready;
        push_s        = ti_write && addr_hit_s && (!full_s || pop_s);
        drop_s        = ti_write && addr_hit_s && full_s && !pop_s;
        free_s        = DEPTH_C - count_r;
        ep_blockready = (free_s >= BLOCK_C);
        ti_ready      = addr_hit_s && !full_s;
    end

    // Pointer and occupancy state; reset discards everything that was stored.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            primed_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                primed_r <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge ti_clk) begin
        if (push_s && !ti_reset) begin
            mem[wr_ptr_r] <= ti_datain;
        end
    end

    // Sticky overflow: a new drop takes priority over a clear on the same edge.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ep_overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
    // Saturating dropped-write counter; increment wins over clear.
    always_ff @(posedge ti_clk or posedge ti_reset) begin
        if (ti_reset) begin
            ep_dropcount <= 16'h0000;
        end else if (drop_s) begin
            if (ep_dropcount != 16'hFFFF) begin
                ep_dropcount <= ep_dropcount + 16'h0001;
            end
        end else if (ep_overflow_clr) begin
            ep_dropcount <= 16'h0000;
        end
    end
`endif

    // Head word is forced to zero until something has been written since reset.
    always_comb begin
        ep_dataout = {DATA_WIDTH{1'b0}};
        if (primed_r) begin
            ep_dataout = mem[rd_ptr_r];
        end else begin
            ep_dataout = {DATA_WIDTH{1'b0}};
        end
    end

    assign ep_count    = count_r;
    assign ep_overflow = overflow_r;

endmodule

// File: tb/tb_pipe_in_fifo.sv
// Directed self-checking bench for pipe_in_fifo at DEPTH=8, BLOCK_SIZE=4, DATA_WIDTH=32.
// Dropped-word counter checks are included when PIPE_IN_FIFO_DROP_COUNT_EN is defined.
module tb_pipe_in_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = 8'h80;
    logic        wr = 1'b0;
    logic [31:0] din = 32'h0;
    logic        ep_ready = 1'b0;
    logic        clr = 1'b0;
    logic        ti_ready;
    logic        blockready;
    logic        valid;
    logic [31:0] dout;
    logic [3:0]  count;
    logic        overflow;
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
    logic [15:0] dropcount;
`endif

    int total = 0;
    int bad = 0;

    pipe_in_fifo #(
        .DATA_WIDTH(32), .DEPTH(8), .BLOCK_SIZE(4), .EP_ADDR(8'h80)
    ) dut (
        .ti_clk(clk), .ti_reset(rst), .ti_addr(addr), .ti_write(wr), .ti_datain(din),
        .ti_ready(ti_ready), .ep_blockready(blockready), .ep_valid(valid),
        .ep_ready(ep_ready), .ep_dataout(dout), .ep_count(count),
        .ep_overflow(overflow), .ep_overflow_clr(clr)
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
        , .ep_dropcount(dropcount)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr = 1'b1;
        din = d;
        step();
        wr = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (blockready !== 1'b1) begin bad++; $display("FAIL reset_blockready: got %b want 1", blockready); end
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dataout: got %h want 0", dout); end
        rst = 1'b0;
        step();
        total++; if (ti_ready !== 1'b1) begin bad++; $display("FAIL reset_ti_ready: got %b want 1", ti_ready); end
    endtask

    task automatic test_basic();
        push_word(32'h11);
        total++; if (valid !== 1'b1 || dout !== 32'h11) begin bad++; $display("FAIL latency1: valid=%b data=%h want 1/11", valid, dout); end
        push_word(32'h22);
        push_word(32'h33);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count: got %0d want 3", count); end
        total++; if (dout !== 32'h11) begin bad++; $display("FAIL basic_head: got %h want 11", dout); end
        total++; if (blockready !== 1'b1) begin bad++; $display("FAIL basic_blockready: got %b want 1", blockready); end
    endtask

    task automatic test_block();
        push_word(32'h44);
        push_word(32'h55);
        total++; if (count !== 4'd5 || blockready !== 1'b0) begin bad++; $display("FAIL block_at5: count=%0d br=%b want 5/0", count, blockready); end
        ep_ready = 1'b1;
        step();
        ep_ready = 1'b0;
        total++; if (count !== 4'd4 || blockready !== 1'b1) begin bad++; $display("FAIL block_at4: count=%0d br=%b want 4/1", count, blockready); end
        total++; if (dout !== 32'h22) begin bad++; $display("FAIL block_head: got %h want 22", dout); end
    endtask

    task automatic test_overflow();
        push_word(32'h66);
        push_word(32'h77);
        push_word(32'h88);
        push_word(32'h99);
        total++; if (count !== 4'd8 || ti_ready !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL full_state: count=%0d rdy=%b ovf=%b want 8/0/0", count, ti_ready, overflow); end
        push_word(32'hD1);
        push_word(32'hD2);
        total++; if (count !== 4'd8 || overflow !== 1'b1) begin bad++; $display("FAIL drop: count=%0d ovf=%b want 8/1", count, overflow); end
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
        total++; if (dropcount !== 16'd2) begin bad++; $display("FAIL dropcount2: got %0d want 2", dropcount); end
`endif
        clr = 1'b1;
        push_word(32'hD3);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins: ovf=%b want 1", overflow); end
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
        total++; if (dropcount !== 16'd3) begin bad++; $display("FAIL inc_wins: got %0d want 3", dropcount); end
`endif
        step();
        clr = 1'b0;
        total++; if (overflow !== 1'b0 || count !== 4'd8) begin bad++; $display("FAIL clear: ovf=%b count=%0d want 0/8", overflow, count); end
`ifdef PIPE_IN_FIFO_DROP_COUNT_EN
        total++; if (dropcount !== 16'd0) begin bad++; $display("FAIL dropcount_clr: got %0d want 0", dropcount); end
`endif
    endtask

    task automatic test_full_pushpop();
        logic [31:0] exp_q [8];
        exp_q = '{32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99, 32'hAA};
        ep_ready = 1'b1;
        push_word(32'hAA);
        total++; if (count !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL full_pp: count=%0d ovf=%b want 8/0", count, overflow); end
        for (int i = 0; i < 8; i++) begin
            total++; if (dout !== exp_q[i]) begin bad++; $display("FAIL drain%0d: got %h want %h", i, dout, exp_q[i]); end
            step();
        end
        ep_ready = 1'b0;
        total++; if (count !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL drained: count=%0d valid=%b want 0/0", count, valid); end
    endtask

    task automatic test_idle_effects();
        ep_ready = 1'b1;
        step();
        ep_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL pop_empty: got %0d want 0", count); end
        addr = 8'h81;
        #1;
        total++; if (ti_ready !== 1'b0) begin bad++; $display("FAIL other_ready: got %b want 0", ti_ready); end
        push_word(32'h5A);
        total++; if (count !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL other_addr: count=%0d valid=%b want 0/0", count, valid); end
        addr = 8'h80;
    endtask

    task automatic test_streaming();
        logic [31:0] head;
        push_word(32'h100);
        ep_ready = 1'b1;
        wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            head = 32'h100 + 32'(i);
            din = head + 32'h1;
            #1;
            total++; if (dout !== head || count !== 4'd1 || valid !== 1'b1) begin bad++; $display("FAIL stream%0d: data=%h count=%0d want %h/1", i, dout, count, head); end
            step();
        end
        wr = 1'b0;
        total++; if (dout !== 32'h114 || count !== 4'd1) begin bad++; $display("FAIL stream_tail: data=%h count=%0d want 114/1", dout, count); end
        step();
        ep_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL stream_empty: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_word(32'h501 + 32'(i));
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_pre: got %0d want 5", count); end
        addr = 8'h81;
        wr = 1'b1;
        din = 32'hBAD;
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL mid_async: count=%0d valid=%b want 0/0", count, valid); end
        total++; if (dout !== 32'h0 || blockready !== 1'b1) begin bad++; $display("FAIL mid_outputs: data=%h br=%b want 0/1", dout, blockready); end
        step();
        rst = 1'b0;
        step();
        wr = 1'b0;
        addr = 8'h80;
        total++; if (count !== 4'd0 || valid !== 1'b0 || dout !== 32'h0) begin bad++; $display("FAIL mid_after: count=%0d valid=%b data=%h want 0/0/0", count, valid, dout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_block();
        test_overflow();
        test_full_pushpop();
        test_idle_effects();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_in_fifo.md
PIPE_IN_FIFO -- requirements
Module: pipe_in_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of host words and endpoint output words.
REQ-002 Parameter DEPTH, default 16: FIFO depth in words; power of two, 2..1024.
REQ-003 Parameter BLOCK_SIZE, default 8: block-throttle threshold in words; 1..DEPTH.
REQ-004 Parameter EP_ADDR, default 8'h80: endpoint address matched against ti_addr.
REQ-005 Port ti_clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port ti_reset  input  1: asynchronous, active-high reset.
REQ-007 Port ti_addr  input  8: host endpoint address.
REQ-008 Port ti_write  input  1: host write strobe.
REQ-009 Port ti_datain  input  DATA_WIDTH: host write data.
REQ-010 Port ti_ready  output  1: endpoint addressed and not full (combinational).
REQ-011 Port ep_blockready  output  1: free space >= BLOCK_SIZE.
REQ-012 Port ep_valid  output  1: head word available.
REQ-013 Port ep_ready  input  1: consumer accepts head word.
REQ-014 Port ep_dataout  output  DATA_WIDTH: head word, first-word-fall-through.
REQ-015 Port ep_count  output  $clog2(DEPTH+1): current occupancy.
REQ-016 Port ep_overflow  output  1: sticky flag, a host write was dropped.
REQ-017 Port ep_overflow_clr  input  1: synchronous clear of ep_overflow (and counter, REQ-034).

Function
REQ-018 Push = ti_write AND (ti_addr == EP_ADDR) AND (not full OR pop); pop = ep_valid AND ep_ready.
REQ-019 Addressed write with full FIFO and no pop shall be dropped and set ep_overflow on that edge.
REQ-020 Pushed word shall appear on ep_dataout with ep_valid high the cycle after the push edge (latency 1).
REQ-021 ep_dataout shall equal storage at read pointer; value undefined-but-stable while ep_valid is low.
REQ-022 Pop with ep_valid low shall have no effect.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance, including at full and at count 1.
REQ-024 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-025 ep_count = pushes minus pops, range 0..DEPTH; full when ep_count == DEPTH, empty when 0.
REQ-026 ep_blockready = (DEPTH - ep_count) >= BLOCK_SIZE, derived combinationally from the count register.
REQ-027 ti_ready = (ti_addr == EP_ADDR) AND (ep_count != DEPTH).
REQ-028 ep_overflow_clr concurrent with a new drop: set wins.
REQ-029 Writes to other addresses shall have no effect on any state.

Reset
REQ-030 While ti_reset is high: pointers 0, ep_count 0, ep_valid 0, ep_overflow 0, ep_blockready 1, ep_dataout 0.
REQ-031 Reset asserted mid-transfer discards all stored words; no push or pop occurs on an edge with reset high.
REQ-032 Storage array is not reset; ep_dataout reads 0 until the first push after reset.

Configuration
REQ-033 Macro PIPE_IN_FIFO_DROP_COUNT_EN selects the dropped-word counter.
REQ-034 Defined: add output ep_dropcount [15:0], +1 per dropped write, saturating at 16'hFFFF, cleared by reset and ep_overflow_clr (increment wins over clear).
REQ-035 Undefined: port ep_dropcount absent; all other behaviour identical.

Verification (DEPTH=8, BLOCK_SIZE=4, DATA_WIDTH=32, EP_ADDR=8'h80)
REQ-036 Reset, then 3 writes 0x11,0x22,0x33 at 0x80, ep_ready=0 -> ep_count=3, ep_valid=1, ep_dataout=0x11, ep_blockready=1.
REQ-037 5th write -> ep_count=5, ep_blockready=0; pop 1 -> ep_count=4, ep_blockready=1.
REQ-038 Fill to 8, 2 more writes -> ep_count=8, ti_ready=0, ep_overflow=1, ep_dropcount=2 (macro on); clear -> 0.
REQ-039 Full, write 0xAA with ep_ready=1 -> ep_count stays 8, 0xAA read as 8th pop, ep_overflow=0.
REQ-040 20 pushes/pops streaming at count 1 -> data order preserved across pointer wrap, no loss.
REQ-041 Reset asserted with count 5 and write at 0x81 -> ep_count=0, ep_valid=0 immediately; 0x81 write ignored.
